// File: rtl/pen_scan_scheduler.sv
// pen_scan_scheduler: time-shares an 8x8 LED matrix between frame-buffer
// display and light-pen raster sensing, and reports the first qualified pen
// hit of each sense pass over a valid/ready interface.
//
// state   | meaning
// IDLE    | matrix dark, scan counters cleared, waiting for enable
// DISPLAY | row-multiplexing frame-buffer content, DISP_FRAMES frames
// SENSE   | one pixel lit at a time, pen photodetector qualified per pixel
module pen_scan_scheduler #(
    parameter int DISP_DWELL  = 2000,
    parameter int DISP_FRAMES = 16,
    parameter int DWELL       = 500,
    parameter int DEBOUNCE    = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [7:0] frame_row_data,
    output logic [2:0] fb_row_addr,
    input  logic       pen_in,
    output logic [7:0] led_row,
    output logic [7:0] led_col,
    output logic       sense_phase,
    output logic       hit_valid,
    output logic [2:0] hit_x,
    output logic [2:0] hit_y,
    input  logic       hit_ready,
    output logic       overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISPLAY = 2'd1,
        SENSE   = 2'd2
    } state_t;

    // One dwell timer serves both phases, so it is sized for the longer dwell.
    localparam int TMAX = (DISP_DWELL > DWELL) ? DISP_DWELL : DWELL;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int FW   = (DISP_FRAMES > 1) ? $clog2(DISP_FRAMES) : 1;
    localparam int PW   = $clog2(DEBOUNCE + 1);

    localparam logic [TW-1:0] DISP_LOAD  = TW'(DISP_DWELL - 1);
    localparam logic [TW-1:0] SENSE_LOAD = TW'(DWELL - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(DISP_FRAMES - 1);
    localparam logic [PW-1:0] PEN_QUAL   = PW'(DEBOUNCE);
    localparam logic [PW-1:0] PEN_PRE    = PW'(DEBOUNCE - 1);

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [FW-1:0] frame_cnt, frame_n;
    logic [2:0]    row_n;
    logic [2:0]    px, px_n;
    logic [2:0]    py, py_n;
    logic [PW-1:0] pen_cnt, pen_n;
    logic          pen_m, pen_s;
    logic          captured, captured_n;
    logic          last_cycle;
    logic          qual, take_hit, accept;
    logic [7:0]    led_row_n, led_col_n;

    // Timer counts down; zero marks the last cycle of a row or pixel.
    assign last_cycle  = (timer == '0);
    assign sense_phase = (state == SENSE);
    assign take_hit    = qual && !captured;
    assign accept      = hit_valid && hit_ready;

    // Two-flop synchronizer for the asynchronous pen pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pen_m <= 1'b0;
            pen_s <= 1'b0;
        end else begin
            pen_m <= pen_in;
            pen_s <= pen_m;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state and scan-position logic; enable low overrides everything.
    always_comb begin
        state_n = state;
        timer_n = timer;
        frame_n = frame_cnt;
        row_n   = fb_row_addr;
        px_n    = px;
        py_n    = py;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = DISPLAY;
                    timer_n = DISP_LOAD;
                    row_n   = '0;
                    frame_n = '0;
                end
            end
            DISPLAY: begin
                if (last_cycle) begin
                    timer_n = DISP_LOAD;
                    row_n   = fb_row_addr + 3'd1;
                    if (fb_row_addr == 3'd7) begin
                        if (frame_cnt == FRAME_LAST) begin
                            state_n = SENSE;
                            timer_n = SENSE_LOAD;
                            frame_n = '0;
                            px_n    = '0;
                            py_n    = '0;
                        end else begin
                            frame_n = frame_cnt + 1'b1;
                        end
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            SENSE: begin
                if (last_cycle) begin
                    timer_n = SENSE_LOAD;
                    px_n    = px + 3'd1;
                    if (px == 3'd7) begin
                        py_n = py + 3'd1;
                        if (py == 3'd7) begin
                            state_n = DISPLAY;
                            timer_n = DISP_LOAD;
                            row_n   = '0;
                            frame_n = '0;
                        end
                    end
                end else begin
                    timer_n = timer - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (!enable) begin
            state_n = IDLE;
            timer_n = '0;
            frame_n = '0;
            row_n   = '0;
            px_n    = '0;
            py_n    = '0;
        end
    end

    // Pen qualifier: consecutive high samples within one pixel, saturating.
    // The last cycle of a pixel clears the count so nothing carries across.
    always_comb begin
        pen_n = '0;
        qual  = 1'b0;
        if ((state == SENSE) && enable && !last_cycle && pen_s) begin
            pen_n = (pen_cnt == PEN_QUAL) ? PEN_QUAL : pen_cnt + 1'b1;
            qual  = (pen_cnt == PEN_PRE);
        end
        captured_n = (state_n == SENSE) && (captured || qual);
    end

    // LED drive for the upcoming cycle; first cycle of each display row is blank.
    always_comb begin
        led_row_n = '0;
        led_col_n = '0;
        case (state_n)
            DISPLAY: begin
                led_row_n = 8'd1 << row_n;
                if (timer_n != DISP_LOAD) led_col_n = frame_row_data;
            end
            SENSE: begin
                led_row_n = 8'd1 << py_n;
                led_col_n = 8'd1 << px_n;
            end
            default: ;
        endcase
    end

    // Scan counters and registered LED outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= '0;
            frame_cnt   <= '0;
            fb_row_addr <= '0;
            px          <= '0;
            py          <= '0;
            pen_cnt     <= '0;
            captured    <= 1'b0;
            led_row     <= '0;
            led_col     <= '0;
        end else begin
            timer       <= timer_n;
            frame_cnt   <= frame_n;
            fb_row_addr <= row_n;
            px          <= px_n;
            py          <= py_n;
            pen_cnt     <= pen_n;
            captured    <= captured_n;
            led_row     <= led_row_n;
            led_col     <= led_col_n;
        end
    end

    // Hit handshake: a capture loads only if the slot is free or being
    // accepted this cycle; otherwise it is dropped and overrun latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid <= 1'b0;
            hit_x     <= '0;
            hit_y     <= '0;
            overrun   <= 1'b0;
        end else if (take_hit && (!hit_valid || accept)) begin
            hit_valid <= 1'b1;
            hit_x     <= px;
            hit_y     <= py;
        end else begin
            if (take_hit) overrun   <= 1'b1;
            if (accept)   hit_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pen_scan_scheduler.sv
// Directed bench for pen_scan_scheduler with small timing parameters.
module tb_pen_scan_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pen_in;
    logic       hit_ready;
    logic [7:0] frame_row_data;
    logic [2:0] fb_row_addr;
    logic [7:0] led_row;
    logic [7:0] led_col;
    logic       sense_phase;
    logic       hit_valid;
    logic [2:0] hit_x;
    logic [2:0] hit_y;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] pen_pat [64];
    logic       exp_hv  [64];
    logic       exp_ov  [64];

    always #5 clk = ~clk;

    // Frame buffer model: row-dependent content exposes address/latency errors.
    assign frame_row_data = 8'hA5 ^ {5'b0, fb_row_addr};

    pen_scan_scheduler #(
        .DISP_DWELL (4),
        .DISP_FRAMES(2),
        .DWELL      (8),
        .DEBOUNCE   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .frame_row_data(frame_row_data),
        .fb_row_addr   (fb_row_addr),
        .pen_in        (pen_in),
        .led_row       (led_row),
        .led_col       (led_col),
        .sense_phase   (sense_phase),
        .hit_valid     (hit_valid),
        .hit_x         (hit_x),
        .hit_y         (hit_y),
        .hit_ready     (hit_ready),
        .overrun       (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {4'h0, sense_phase, fb_row_addr, led_row, led_col,
                hit_valid, hit_x, hit_y, overrun};
    endfunction

    function automatic logic [31:0] hit_out();
        return {24'h0, hit_valid, hit_x, hit_y, overrun};
    endfunction

    // Called at the negedge of DISPLAY cycle 0; returns at the first SENSE cycle.
    task automatic display_pass();
        for (int f = 0; f < 2; f++) begin
            for (int r = 0; r < 8; r++) begin
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] er;
                    logic [7:0] ec;
                    er = 8'd1 << r;
                    ec = (k == 0) ? 8'h00 : (8'hA5 ^ 8'(r));
                    chk("disp", {12'h0, sense_phase, fb_row_addr, led_row, led_col},
                        {12'h0, 1'b0, 3'(r), er, ec});
                    @(negedge clk);
                end
            end
        end
    endtask

    // Called at the first SENSE cycle; returns at DISPLAY cycle 0.
    task automatic sense_pass();
        for (int y = 0; y < 8; y++) begin
            for (int x = 0; x < 8; x++) begin
                for (int k = 0; k < 8; k++) begin
                    int p = y * 8 + x;
                    chk("sense_led", {15'h0, sense_phase, led_row, led_col},
                        {15'h0, 1'b1, 8'd1 << y, 8'd1 << x});
                    if (k == 7)
                        chk("sense_hit", {30'h0, hit_valid, overrun},
                            {30'h0, exp_hv[p], exp_ov[p]});
                    pen_in = pen_pat[p][k];
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic set_pass(input int hv_from, input int ov_from);
        for (int p = 0; p < 64; p++) begin
            pen_pat[p] = 8'h00;
            exp_hv[p]  = (p >= hv_from);
            exp_ov[p]  = (p >= ov_from);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        enable    = 1'b0;
        pen_in    = 1'b0;
        hit_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", all_out(), 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_hold", all_out(), 32'h0);

        // Enable: next cycle is DISPLAY row 0, checked by the first display pass.
        enable = 1'b1;
        @(negedge clk);
        display_pass();

        // Pass 1: no pen activity.
        set_pass(64, 64);
        sense_pass();
        display_pass();

        // Pass 2: glitches, split pulses, boundary-straddling pulse, then a hit
        // at (5,2) and a later pulse at (6,2) that must be ignored.
        set_pass(21, 64);
        pen_pat[10] = 8'h03;
        pen_pat[12] = 8'h1B;
        pen_pat[14] = 8'hF0;
        pen_pat[21] = 8'h1F;
        pen_pat[22] = 8'h1F;
        sense_pass();
        chk("hit_52", hit_out(), {24'h0, 1'b1, 3'd5, 3'd2, 1'b0});
        display_pass();

        // Pass 3: hit (1,6) with the slot still full -> dropped, overrun.
        set_pass(0, 49);
        pen_pat[49] = 8'h1F;
        sense_pass();
        chk("overrun_keep", hit_out(), {24'h0, 1'b1, 3'd5, 3'd2, 1'b1});
        hit_ready = 1'b1;
        @(negedge clk);
        chk("accept", {31'h0, hit_valid}, 32'h0);
        hit_ready = 1'b0;

        // Pass 4: hit at (1,0), then drop enable mid-SENSE.
        n = 0;
        while (!sense_phase && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("sense_reached", {31'h0, sense_phase}, 32'h1);
        repeat (8) @(negedge clk);
        pen_in = 1'b1;
        repeat (5) @(negedge clk);
        pen_in = 1'b0;
        repeat (5) @(negedge clk);
        chk("sense_px", {16'h0, led_row, led_col}, {16'h0, 8'h01, 8'h04});
        chk("hit_10", hit_out(), {24'h0, 1'b1, 3'd1, 3'd0, 1'b1});
        enable = 1'b0;
        @(negedge clk);
        chk("disable", all_out(),
            {4'h0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd1, 3'd0, 1'b1});
        repeat (3) @(negedge clk);
        chk("idle_retain", all_out(),
            {4'h0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 3'd1, 3'd0, 1'b1});
        hit_ready = 1'b1;
        @(negedge clk);
        hit_ready = 1'b0;
        chk("idle_accept", hit_out(), {24'h0, 1'b0, 3'd1, 3'd0, 1'b1});

        // Re-enable: full restart at row 0, frame 0.
        enable = 1'b1;
        @(negedge clk);
        display_pass();
        chk("resense", {30'h0, sense_phase, hit_valid}, {30'h0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
